// File: rtl/fluxo_dados_contador_param_pkg.sv
// fluxo_dados_contador_param_pkg: digit-count helper and hex 7-segment codes
package fluxo_dados_contador_param_pkg;

    function automatic int digitos(input int n);
        return (n + 3) / 4;
    endfunction

    // active-low segments in {g,f,e,d,c,b,a} order, indexed by hex value (F at the top)
    localparam logic [15:0][6:0] SEG_CODES = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/contador_ud_mod.sv
// contador_ud_mod: modulo up/down counter with saturating load and terminal flag
module contador_ud_mod #(
    parameter int N      = 4,
    parameter int MODULO = 16
) (
    input  logic         clock_i,
    input  logic         zera_i,
    input  logic         carrega_i,
    input  logic         conta_i,
    input  logic         decrementa_i,
    input  logic [N-1:0] chaves_i,
    output logic [N-1:0] contagem_o,
    output logic         fim_o
);
    localparam logic [N-1:0] ULTIMO  = N'(MODULO - 1);
    localparam logic [N:0]   MOD_EXT = (N + 1)'(MODULO);

    logic [N-1:0] contagem_q, contagem_d;

    // load clamps to the last valid value; counting wraps in either direction
    always_comb begin
        contagem_d = carrega_i ? (({1'b0, chaves_i} < MOD_EXT) ? chaves_i : ULTIMO)
                   : !conta_i  ? contagem_q
                   : decrementa_i ? ((contagem_q == '0) ? ULTIMO : contagem_q - 1'b1)
                   : ((contagem_q == ULTIMO) ? '0 : contagem_q + 1'b1);
    end

    // count register with synchronous clear
    always_ff @(posedge clock_i) begin
        if (zera_i) contagem_q <= '0;
        else        contagem_q <= contagem_d;
    end

    assign contagem_o = contagem_q;
    assign fim_o      = decrementa_i ? (contagem_q == '0) : (contagem_q == ULTIMO);
endmodule

// File: rtl/hexa7seg.sv
// hexa7seg: one hex nibble to its 7-segment code
module hexa7seg import fluxo_dados_contador_param_pkg::*; (
    input  logic [3:0] hexa_i,
    output logic [6:0] display_o
);
    assign display_o = SEG_CODES[hexa_i];
endmodule

// File: rtl/fluxo_dados_contador_param.sv
// fluxo_dados_contador_param: parametrised count/compare datapath with match pulse, hit counter and hex displays
module fluxo_dados_contador_param import fluxo_dados_contador_param_pkg::*; #(
    parameter int  N         = 4,
    parameter int  MODULO    = 16,
    parameter int  W_ACERTOS = 8,
    localparam int DIGITOS   = digitos(N)
) (
    input  logic                   clock,
    input  logic                   zera,
    input  logic                   carrega,
    input  logic                   conta,
    input  logic                   decrementa,
    input  logic [N-1:0]           chaves,
    output logic                   menor,
    output logic                   maior,
    output logic                   igual,
    output logic                   fim,
    output logic                   igual_pulso,
    output logic [W_ACERTOS-1:0]   db_acertos,
    output logic [N-1:0]           db_contagem,
    output logic [7*DIGITOS-1:0]   display_CONT,
    output logic [7*DIGITOS-1:0]   display_CHAVES
);
    logic [N-1:0]           contagem;
    logic                   igual_ant_q;
    logic                   igual_pulso_q, igual_pulso_d;
    logic [W_ACERTOS-1:0]   acertos_q, acertos_d;
    logic [4*DIGITOS-1:0]   cont_ext, chaves_ext;

    contador_ud_mod #(.N(N), .MODULO(MODULO)) u_contador (
        .clock_i      (clock),
        .zera_i       (zera),
        .carrega_i    (carrega),
        .conta_i      (conta),
        .decrementa_i (decrementa),
        .chaves_i     (chaves),
        .contagem_o   (contagem),
        .fim_o        (fim)
    );

    // compare against the raw switches, so switches beyond the modulus keep menor high
    assign menor = contagem < chaves;
    assign maior = contagem > chaves;
    assign igual = contagem == chaves;

    // rising-edge detect of igual and a hit counter that sticks at all-ones
    always_comb begin
        igual_pulso_d = igual && !igual_ant_q;
        acertos_d     = (igual_pulso_q && acertos_q != '1) ? acertos_q + 1'b1 : acertos_q;
    end

    // igual_ant resets high so a match already present at reset release does not pulse
    always_ff @(posedge clock) begin
        if (zera) begin
            igual_ant_q   <= 1'b1;
            igual_pulso_q <= 1'b0;
            acertos_q     <= '0;
        end else begin
            igual_ant_q   <= igual;
            igual_pulso_q <= igual_pulso_d;
            acertos_q     <= acertos_d;
        end
    end

    assign igual_pulso = igual_pulso_q;
    assign db_acertos  = acertos_q;
    assign db_contagem = contagem;
    assign cont_ext    = (4 * DIGITOS)'(contagem);
    assign chaves_ext  = (4 * DIGITOS)'(chaves);

    for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
        hexa7seg u_cont   (.hexa_i(cont_ext[4*g +: 4]),   .display_o(display_CONT[7*g +: 7]));
        hexa7seg u_chaves (.hexa_i(chaves_ext[4*g +: 4]), .display_o(display_CHAVES[7*g +: 7]));
    end
endmodule

// File: doc/fluxo_dados_contador_param.md
# fluxo_dados_contador_param

Parametrised counter/comparator datapath for the lab experiments. It generalises the fixed 4-bit load/count/compare datapath with configurable width, configurable modulo and an up/down mode. It also adds a registered equality-rise pulse, a saturating match counter and multi-digit hex display outputs. It sits under the experiment top level and is driven by the control unit (`zera`, `carrega`, `conta`, `decrementa`) and the board switches (`chaves`).

## Interface
- `N`, 4: counter and switch width in bits, 2..16.
- `MODULO`, 16: count modulus, 2..2^N; the count range is 0..MODULO-1.
- `W_ACERTOS`, 8: width of the match counter.
- `DIGITOS`, derived as ceil(N/4); not overridable.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `zera`  in  1: synchronous, active-high reset.
- `carrega`  in  1: load `chaves` into the counter.
- `conta`  in  1: count enable.
- `decrementa`  in  1: direction (0 = up, 1 = down).
- `chaves`  in  N: switch value, used as both load data and compare operand.
- `menor`  out  1: `contagem` < `chaves`, unsigned.
- `maior`  out  1: `contagem` > `chaves`, unsigned.
- `igual`  out  1: `contagem` == `chaves`.
- `fim`  out  1: counter is at the terminal value for the current direction.
- `igual_pulso`  out  1: one-cycle pulse on a rise of `igual`.
- `db_acertos`  out  W_ACERTOS: number of `igual_pulso` events, saturating.
- `db_contagem`  out  N: current count.
- `display_CONT`  out  7*DIGITOS: 7-segment codes for `contagem`; digit 0 is in bits [6:0].
- `display_CHAVES`  out  7*DIGITOS: 7-segment codes for `chaves`.

## Operation
- Counter register update priority: `zera` > `carrega` > `conta` > hold.
- Load:
  - Loads `chaves` when `chaves` < MODULO.
  - Otherwise loads MODULO-1 (saturating).
- Count up: MODULO-1 wraps to 0.
- Count down: 0 wraps to MODULO-1.
- `decrementa` is sampled only in cycles where `conta` is high and `carrega` is low.
- `fim` is combinational:
  - `decrementa`=0: high when `contagem`==MODULO-1.
  - `decrementa`=1: high when `contagem`==0.
  - Independent of `conta`.
- Comparator:
  - Combinational, unsigned, full N bits.
  - Exactly one of `menor`/`maior`/`igual` is high at all times.
  - It does not saturate `chaves`, so `chaves` ≥ MODULO yields `menor`=1 permanently.
- Edge detect:
  - Register `igual_ant` holds the previous-cycle `igual`.
  - `igual_pulso` is registered and is set for one cycle after any cycle where `igual`=1 and `igual_ant`=0.
- `db_acertos` increments by 1 in each cycle where `igual_pulso`=1 and holds at 2^W_ACERTOS-1.
- Displays:
  - One hexa7seg encoding per nibble, using the team's existing segment polarity.
  - `chaves`/`contagem` are zero-extended to 4*DIGITOS bits.
- Reset values (while `zera`=1 and after it is released):
  - `contagem`=0, `igual_pulso`=0, `db_acertos`=0.
  - `igual_ant`=1, which suppresses a spurious pulse immediately after reset.
  - Combinational outputs follow from `contagem`=0.

## Timing
- Count/load latency: 1 cycle. `contagem`, and all compare and `fim` outputs derived from it, reflect the new value after the edge that samples the command.
- `igual_pulso` latency:
  - `igual` rises combinationally after the edge that changes `contagem`.
  - `igual_pulso` is high during the following cycle.
  - `db_acertos` updates one cycle after that.
- A `chaves` change can raise `igual` with no clock edge; the pulse still follows one edge later.
- If `igual` stays high, no further pulses occur. It must fall and rise again to produce another pulse.
- `zera` asserted mid-count takes effect at the next edge and overrides a simultaneous `carrega`/`conta`.
- `carrega` and `conta` together: load wins, no count.

## Structure
- Shared package/include holds:
  - A `DIGITOS` computation function, ceil(N/4).
  - The 7-segment code constants already used by hexa7seg.
- Sub-module `contador_ud_mod`, parameters N and MODULO: the load/up/down/wrap register plus `fim`.
- The top level instantiates:
  - `contador_ud_mod`.
  - Inline comparator and edge-detect logic.
  - The `igual_pulso` register and `db_acertos` counter.
  - A generate loop of existing `hexa7seg` instances, 2*DIGITOS in total.

## Test plan
- Defaults (N=4, MODULO=16): reset, then `conta`=1 for 17 cycles.
  - `contagem` goes 0..15,0; `fim`=1 only at 15.
- N=4, MODULO=10, `decrementa`=1: load `chaves`=3, then count.
  - Sequence 3,2,1,0,9,8; `fim`=1 only at 0.
- N=4, MODULO=10: load `chaves`=12.
  - `contagem`=9 and `menor`=1.
- N=8, MODULO=200, `chaves`=0x05: count up from 0.
  - `igual`=1 at `contagem`=5.
  - `igual_pulso` is high for exactly one cycle, next cycle.
  - `db_acertos`=1 afterwards.
  - `display_CONT`/`display_CHAVES` digit1 code is '0' and digit0 code is '5' for both.
- Simultaneous `carrega`=1, `conta`=1, `chaves`=7: `contagem`=7.
  - Then assert `zera` together with `carrega`: `contagem`=0, `db_acertos`=0, no `igual_pulso` in the cycle after reset release with `chaves`=0.
- W_ACERTOS=2: toggle `chaves` between the count and another value to generate 5 pulses.
  - `db_acertos` saturates at 3.
